// File: rtl/ssd1306_pkg.sv
// Shared types and constants for the SSD1306 SPI link.
// Used by the SPI transmitter and its half-period timer.
package ssd1306_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_GAP,
    S_CS_HOLD,
    S_CS_IDLE
  } e_spi_tx_state;

  localparam int unsigned SPI_BYTE_BITS = 8;
  localparam int unsigned SCLK_HALF_PERIOD_MAX = 255;

endpackage

// File: rtl/ssd1306_spi_half_period_timer.sv
// Counts clk_in cycles of one SCLK phase.
// Pulses o_expired on the last cycle of each H-cycle phase.
module ssd1306_spi_half_period_timer #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned CNT_BITS    = 3
) (
  input  logic clk_in,
  input  logic resetn_in,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [CNT_BITS-1:0] LP_H = CNT_BITS'(HALF_PERIOD);
  localparam logic [CNT_BITS-1:0] LP_ONE = CNT_BITS'(1);

  logic [CNT_BITS-1:0] r_cnt;

  assign o_expired = i_en && (r_cnt == LP_H);

  // Phase counter: 1..H while enabled, restarts at 1 on load or expiry
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_cnt <= '0;
    end else if (i_load || o_expired) begin
      r_cnt <= LP_ONE;
    end else if (i_en) begin
      r_cnt <= r_cnt + LP_ONE;
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/ssd1306_spi_tx.sv
// SPI mode-0 byte transmitter for the SSD1306 link.
// Frames bursts with CSn, released after a byte flagged last.
module ssd1306_spi_tx
  import ssd1306_pkg::*;
#(
  parameter int unsigned SCLK_HALF_PERIOD = 4
) (
  input  logic       clk_in,
  input  logic       resetn_in,
  input  logic       tx_trigger_in,
  input  logic [7:0] tx_data_in,
  input  logic       tx_last_byte_in,
  output logic       tx_ready_out,
  output logic       spi_sclk_out,
  output logic       spi_mosi_out,
  output logic       spi_csn_out
);

  localparam int unsigned HALF_CNT_BITS =
    $clog2(SCLK_HALF_PERIOD + 1);
  localparam logic [2:0] LP_LAST_BIT =
    3'(SPI_BYTE_BITS - 1);

  generate
    if (SCLK_HALF_PERIOD < 1 ||
        SCLK_HALF_PERIOD > SCLK_HALF_PERIOD_MAX) begin : g_bad_h
      $error("SCLK_HALF_PERIOD must be in 1..255");
    end
  endgenerate

  e_spi_tx_state r_state;
  e_spi_tx_state w_next;

  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic       r_last;
  logic       r_sclk;
  logic       r_csn;
  logic       r_ready;

  logic w_accept;
  logic w_en;
  logic w_expired;
  logic w_adv;

  assign w_accept = tx_trigger_in && r_ready;

  assign w_en = (r_state == S_LOW)     ||
                (r_state == S_HIGH)    ||
                (r_state == S_CS_HOLD) ||
                (r_state == S_CS_IDLE);

  ssd1306_spi_half_period_timer #(
    .HALF_PERIOD (SCLK_HALF_PERIOD),
    .CNT_BITS    (HALF_CNT_BITS)
  ) u_timer (
    .clk_in    (clk_in),
    .resetn_in (resetn_in),
    .i_load    (w_accept),
    .i_en      (w_en),
    .o_expired (w_expired)
  );

  // Next-state decode; w_adv marks the SCLK falling edge between bits
  always_comb begin
    w_next = r_state;
    w_adv  = 1'b0;
    unique case (r_state)
      S_IDLE, S_GAP: begin
        if (w_accept) w_next = S_LOW;
      end
      S_LOW: begin
        if (w_expired) w_next = S_HIGH;
      end
      S_HIGH: begin
        if (w_expired) begin
          if (r_bit == LP_LAST_BIT) begin
            w_next = r_last ? S_CS_HOLD : S_GAP;
          end else begin
            w_next = S_LOW;
            w_adv  = 1'b1;
          end
        end
      end
      S_CS_HOLD: begin
        if (w_expired) w_next = S_CS_IDLE;
      end
      S_CS_IDLE: begin
        if (w_expired) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State and registered pin levels, all derived from the next state
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_state <= S_IDLE;
      r_sclk  <= 1'b0;
      r_csn   <= 1'b1;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_next;
      r_sclk  <= (w_next == S_HIGH);
      r_csn   <= (w_next == S_IDLE) ||
                 (w_next == S_CS_IDLE);
      r_ready <= (w_next == S_IDLE) ||
                 (w_next == S_GAP);
    end
  end

  // Byte datapath: load on accept, shift on each SCLK falling edge
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_shift <= '0;
      r_bit   <= '0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_shift <= tx_data_in;
      r_bit   <= '0;
      r_last  <= tx_last_byte_in;
    end else if (w_adv) begin
      r_shift <= {r_shift[6:0], 1'b0};
      r_bit   <= r_bit + 3'd1;
    end
  end

  assign tx_ready_out = r_ready;
  assign spi_sclk_out = r_sclk;
  assign spi_mosi_out = r_shift[7];
  assign spi_csn_out  = r_csn;

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// Bench for ssd1306_spi_tx: H=4 and H=1 instances.
// Waveforms checked against cycle formulas and an SPI decoder.
module tb_ssd1306_spi_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       trig [2];
  logic [7:0] data [2];
  logic       last [2];
  logic       rdy  [2];
  logic       sclk [2];
  logic       mosi [2];
  logic       csn  [2];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] got0 [$];
  logic [7:0] got1 [$];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  int         rise0 [$];

  logic       ps  [2] = '{default: 1'b0};
  logic       pm  [2] = '{default: 1'b0};
  logic       pc  [2] = '{default: 1'b1};
  logic       acc [2] = '{default: 1'b0};
  logic [7:0] sh  [2] = '{default: 8'h00};
  int         nb  [2] = '{default: 0};
  bit         rst_seen = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ssd1306_spi_tx #(.SCLK_HALF_PERIOD(4)) u_h4 (
    .clk_in          (clk),
    .resetn_in       (rst_n),
    .tx_trigger_in   (trig[0]),
    .tx_data_in      (data[0]),
    .tx_last_byte_in (last[0]),
    .tx_ready_out    (rdy[0]),
    .spi_sclk_out    (sclk[0]),
    .spi_mosi_out    (mosi[0]),
    .spi_csn_out     (csn[0])
  );

  ssd1306_spi_tx #(.SCLK_HALF_PERIOD(1)) u_h1 (
    .clk_in          (clk),
    .resetn_in       (rst_n),
    .tx_trigger_in   (trig[1]),
    .tx_data_in      (data[1]),
    .tx_last_byte_in (last[1]),
    .tx_ready_out    (rdy[1]),
    .spi_sclk_out    (sclk[1]),
    .spi_mosi_out    (mosi[1]),
    .spi_csn_out     (csn[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h t=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  always @(negedge rst_n) rst_seen = 1'b1;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      acc[i] = trig[i] && rdy[i] && rst_n;
  end

  // SPI slave model plus bus-rule checks
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) chk("ready_after_accept", rdy[i], 0);
      chk("sclk_high_csn_high", sclk[i] & csn[i], 0);
      if (ps[i] && sclk[i])
        chk("mosi_stable", mosi[i], pm[i]);
      if (!rst_seen && csn[i] !== pc[i])
        chk("csn_edge_sclk_low", ps[i] | sclk[i], 0);
      if (csn[i]) begin
        nb[i] = 0;
      end else if (sclk[i] && !ps[i]) begin
        sh[i] = {sh[i][6:0], mosi[i]};
        nb[i]++;
        if (i == 0) rise0.push_back(cyc);
        if (nb[i] == 8) begin
          if (i == 0) got0.push_back(sh[i]);
          else got1.push_back(sh[i]);
          nb[i] = 0;
        end
      end
      ps[i] = sclk[i];
      pm[i] = mosi[i];
      pc[i] = csn[i];
    end
    rst_seen = 1'b0;
  end

  function automatic int hp(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic compare_q(input int i, input string tag);
    if (i == 0) begin
      chk({tag, "_count"}, got0.size(), exp0.size());
      for (int k = 0; k < exp0.size() && k < got0.size(); k++)
        chk({tag, "_byte"}, got0[k], exp0[k]);
      got0.delete();
      exp0.delete();
    end else begin
      chk({tag, "_count"}, got1.size(), exp1.size());
      for (int k = 0; k < exp1.size() && k < got1.size(); k++)
        chk({tag, "_byte"}, got1[k], exp1[k]);
      got1.delete();
      exp1.delete();
    end
  endtask

  task automatic idle_wait(input int i, input int k,
                           input logic ec);
    for (int j = 0; j < k; j++) begin
      @(negedge clk);
      chk("idle_ready", rdy[i], 1);
      chk("idle_sclk", sclk[i], 0);
      chk("idle_csn", csn[i], ec);
    end
  endtask

  // Sends one byte; called at a negedge with ready high.
  // Returns at the negedge of the first ready-high cycle.
  task automatic byte_wave(input int i, input logic [7:0] d,
                           input logic l, input bit hold,
                           input bit noise);
    int h;
    int endn;
    int bi;
    logic es, ec, er, em;
    h = hp(i);
    endn = l ? 18 * h + 1 : 16 * h + 1;
    chk("pre_ready", rdy[i], 1);
    if (i == 0) exp0.push_back(d);
    else exp1.push_back(d);
    trig[i] = 1'b1;
    data[i] = d;
    last[i] = l;
    @(posedge clk);
    @(negedge clk);
    if (!hold) trig[i] = 1'b0;
    for (int n = 1; n <= endn; n++) begin
      if (n > 1) @(negedge clk);
      em = d[0];
      es = 1'b0;
      if (n <= 16 * h) begin
        bi = 7 - (n - 1) / (2 * h);
        es = 1'(((n - 1) / h) % 2);
        ec = 1'b0;
        er = 1'b0;
        em = d[bi];
      end else if (!l) begin
        ec = 1'b0;
        er = 1'b1;
      end else if (n <= 17 * h) begin
        ec = 1'b0;
        er = 1'b0;
      end else if (n <= 18 * h) begin
        ec = 1'b1;
        er = 1'b0;
      end else begin
        ec = 1'b1;
        er = 1'b1;
      end
      chk("sclk", sclk[i], es);
      chk("csn", csn[i], ec);
      chk("ready", rdy[i], er);
      chk("mosi", mosi[i], em);
      if (hold && n == 3) begin
        data[i] = 8'h11;
        last[i] = 1'b1;
      end
      if (noise)
        trig[i] = (n >= 2 && n < 16 * h) ?
                  1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  initial begin
    int a;
    int nbytes;
    int ri;
    logic [7:0] rd;
    logic rl;
    for (int i = 0; i < 2; i++) begin
      trig[i] = 1'b0;
      data[i] = 8'h00;
      last[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_csn", csn[i], 1);
      chk("rst_sclk", sclk[i], 0);
      chk("rst_mosi", mosi[i], 0);
      chk("rst_ready", rdy[i], 1);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);

    // single byte, rising-edge sample times
    rise0.delete();
    a = cyc + 1;
    byte_wave(0, 8'hA5, 1'b1, 1'b0, 1'b0);
    chk("rise_count", rise0.size(), 8);
    for (int k = 0; k < 8 && k < rise0.size(); k++)
      chk("rise_cycle", rise0[k] - a + 1, 5 + 8 * k);
    compare_q(0, "single");

    // burst of three, back to back
    byte_wave(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    byte_wave(0, 8'hFF, 1'b0, 1'b0, 1'b0);
    byte_wave(0, 8'h00, 1'b1, 1'b0, 1'b0);
    compare_q(0, "burst");

    // trigger held high, data changed mid-byte
    byte_wave(0, 8'h5A, 1'b0, 1'b1, 1'b0);
    byte_wave(0, 8'h11, 1'b1, 1'b0, 1'b0);
    idle_wait(0, 12, 1'b1);
    compare_q(0, "hold");

    // asynchronous reset in the middle of a byte
    trig[0] = 1'b1;
    data[0] = 8'h6E;
    last[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trig[0] = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_csn", csn[0], 1);
    chk("arst_sclk", sclk[0], 0);
    chk("arst_mosi", mosi[0], 0);
    chk("arst_ready", rdy[0], 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle_wait(0, 2, 1'b1);
    byte_wave(0, 8'h81, 1'b1, 1'b0, 1'b0);
    compare_q(0, "after_reset");

    // H=1 back to back
    byte_wave(1, 8'h55, 1'b0, 1'b0, 1'b0);
    byte_wave(1, 8'hAA, 1'b1, 1'b0, 1'b0);
    compare_q(1, "h1_b2b");

    // random bursts with random gaps and busy-time triggers
    for (int it = 0; it < 8; it++) begin
      ri = $urandom_range(0, 1);
      nbytes = $urandom_range(1, 4);
      for (int b = 0; b < nbytes; b++) begin
        rd = 8'($urandom);
        rl = (b == nbytes - 1) ? 1'b1 :
             1'($urandom_range(0, 3) == 0);
        byte_wave(ri, rd, rl, 1'b0, 1'b1);
        idle_wait(ri, $urandom_range(0, 3), rl);
      end
      compare_q(ri, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
